// File: rtl/cnn_pkg.sv
// Shared CNN constants and types for the ReLU scheduling stage.
// Holds map geometry, element/address widths, the scheduler state encoding
// and the signed element type.
package cnn_pkg;

  localparam int unsigned RELU_DATA_WIDTH = 69;
  localparam int unsigned RELU_X          = 24;
  localparam int unsigned RELU_Y          = 24;
  localparam int unsigned RELU_NUM_CH     = 8;
  localparam int unsigned RELU_ADDR_W     = 13;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } relu_state_t;

  typedef logic signed [RELU_DATA_WIDTH-1:0] relu_data_t;

endpackage

// File: rtl/relu_scheduler_if.sv
// Buffer-side bus of the ReLU scheduler.
// Read side : rd_en/rd_addr towards the conv result buffer, rd_data back
//             (valid one cycle after rd_en).
// Write side: wr_en/wr_addr/wr_data towards the ReLU result buffer.
// master = scheduler, slave = buffers.
interface relu_scheduler_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RELU_DATA_WIDTH,
  parameter int unsigned ADDR_W     = RELU_ADDR_W
) ();

  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );

endinterface

// File: rtl/relu_lane.sv
// Single ReLU lane: registered write stage of the scheduler pipeline.
// Ports: clk, rst_n (async active-low), flush (drop everything, back to
// reset values), valid/addr/data (stage-2 element), wr_en/wr_addr/wr_data
// (registered write), neg (registered: the written element was negative).
module relu_lane
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RELU_DATA_WIDTH,
  parameter int unsigned ADDR_W     = RELU_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  neg
);

  // Address/data hold their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      neg     <= 1'b0;
    end else if (flush) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      neg     <= 1'b0;
    end else begin
      wr_en <= valid;
      neg   <= valid & data[DATA_WIDTH-1];
      if (valid) begin
        wr_addr <= addr;
        wr_data <= data[DATA_WIDTH-1] ? '0 : data;
      end
    end
  end

endmodule

// File: rtl/relu_scheduler.sv
// Time-multiplexed ReLU sequencer: streams NUM_CH MAP_XxMAP_Y maps from the
// conv buffer through one ReLU lane into the ReLU buffer, one element/cycle.
// Ports: clk, rst_n (async active-low), start/pause/abort controls,
// bus (relu_scheduler_if.master: conv read + ReLU write), busy, done
// (one-cycle pulse), neg_count (zeroed elements of the last run).
// Optional: RELU_STATS_EN builds the saturating neg_count counter; without
// it neg_count is tied to 0.
module relu_scheduler
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RELU_DATA_WIDTH,
  parameter int unsigned MAP_X      = RELU_X,
  parameter int unsigned MAP_Y      = RELU_Y,
  parameter int unsigned NUM_CH     = RELU_NUM_CH,
  parameter int unsigned ADDR_W     = RELU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  relu_scheduler_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   neg_count
);

  localparam int unsigned     NUM_ELEM  = NUM_CH * MAP_X * MAP_Y;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ELEM - 1);

  relu_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              v2_q;
  logic [ADDR_W-1:0] a2_q;
  logic              flush;
  logic              clr_stats;

  logic                  lane_wr_en;
  logic [ADDR_W-1:0]     lane_wr_addr;
  logic [DATA_WIDTH-1:0] lane_wr_data;
  logic                  lane_neg;

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    flush     = 1'b0;
    clr_stats = 1'b0;

    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start && !abort) begin
          state_d   = RUN;
          clr_stats = 1'b1;
        end
      end
      RUN: begin
        if (!pause) begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q;
          addr_d    = addr_q + ADDR_W'(1);
          if (addr_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      // Drained once neither the read stage nor the data stage holds an element.
      DRAIN: begin
        if (!rd_en_q && !v2_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      addr_d    = '0;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
      done_d    = 1'b0;
      flush     = 1'b1;
    end

    // Registered from the current state so busy rises one cycle after start.
    busy_d = (state_d == RUN || state_d == DRAIN) && (state_q != IDLE);
  end

  // State, read stage and stage-2 carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      v2_q      <= 1'b0;
      a2_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      v2_q      <= rd_en_q & ~flush;
      if (flush)        a2_q <= '0;
      else if (rd_en_q) a2_q <= rd_addr_q;
    end
  end

  relu_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_lane (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .valid   (v2_q),
    .addr    (a2_q),
    .data    (bus.rd_data),
    .wr_en   (lane_wr_en),
    .wr_addr (lane_wr_addr),
    .wr_data (lane_wr_data),
    .neg     (lane_neg)
  );

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = lane_wr_en;
  assign bus.wr_addr = lane_wr_addr;
  assign bus.wr_data = lane_wr_data;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef RELU_STATS_EN
  localparam logic [ADDR_W:0] NEG_MAX = (ADDR_W+1)'(NUM_ELEM);
  logic [ADDR_W:0] neg_q;

  // Counts zeroed writes one cycle after they leave the lane; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= '0;
    end else if (flush || clr_stats) begin
      neg_q <= '0;
    end else if (lane_neg && neg_q != NEG_MAX) begin
      neg_q <= neg_q + (ADDR_W+1)'(1);
    end
  end

  assign neg_count = neg_q;
`else
  logic unused_stats;
  assign unused_stats = lane_neg | clr_stats;
  assign neg_count    = '0;
`endif

endmodule
